// File: rtl/alu_op_issuer.sv
// Request queue + issue FSM driving one op at a time into the decoder/ALU.
// Optional OPCODE_CHECK_EN rejects undefined opcodes without touching the ALU.
module alu_op_issuer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_opcode,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [3:0]       rsp_opcode,
    output logic             rsp_err,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
    localparam logic [7:0] L_TLAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]       r_q_op [DEPTH];
    logic [WIDTH-1:0] r_q_a  [DEPTH];
    logic [WIDTH-1:0] r_q_b  [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [7:0]       r_tcnt;

    logic [3:0]       r_alu_op;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [WIDTH-1:0] r_rsp_result;
    logic [3:0]       r_rsp_flags;
    logic [3:0]       r_rsp_op;
    logic             r_rsp_err;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_illegal;
    logic             w_timeout;
    logic [3:0]       w_head_op;

    assign w_full    = (r_count == L_FULL);
    assign w_empty   = (r_count == '0);
    assign w_push    = req_valid && !w_full;
    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    assign w_timeout = (r_tcnt == L_TLAST);
    assign w_head_op = r_q_op[r_rptr];

`ifdef OPCODE_CHECK_EN
    // Undefined encodings: 0010..0111 and 1111
    assign w_illegal = (w_head_op[3:1] == 3'b001) ||
                       (w_head_op[3:2] == 2'b01)  ||
                       (w_head_op == 4'hF);
`else
    assign w_illegal = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_next = w_illegal ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (alu_done || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_op[r_wptr] <= req_opcode;
            r_q_a[r_wptr]  <= req_a;
            r_q_b[r_wptr]  <= req_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_tcnt       <= '0;
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_op     <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr   <= r_rptr + 1'b1;
                r_alu_op <= w_head_op;
                r_alu_a  <= r_q_a[r_rptr];
                r_alu_b  <= r_q_b[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (r_state == S_ISSUE) begin
                r_tcnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            // Done wins over a timeout landing on the same cycle
            if (r_state == S_WAIT && alu_done) begin
                r_rsp_result <= alu_result;
                r_rsp_flags  <= alu_flags;
                r_rsp_op     <= r_alu_op;
                r_rsp_err    <= 1'b0;
            end else if (r_state == S_WAIT && w_timeout) begin
                r_rsp_result <= '0;
                r_rsp_flags  <= '0;
                r_rsp_op     <= r_alu_op;
                r_rsp_err    <= 1'b1;
            end else if (w_pop && w_illegal) begin
                r_rsp_result <= '0;
                r_rsp_flags  <= '0;
                r_rsp_op     <= w_head_op;
                r_rsp_err    <= 1'b1;
            end
        end
    end

    assign req_ready  = !w_full;
    assign alu_opcode = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_start  = (r_state == S_ISSUE);
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_opcode = r_rsp_op;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != S_IDLE) || !w_empty;
endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: behavioural ALU responder plus per-scenario
// checks against expectations derived from the op/timeout rules.
module tb_alu_op_issuer;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       req_opcode = '0;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic [3:0]       alu_opcode;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_start;
    logic             alu_done;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;
    logic [3:0]       rsp_opcode;
    logic             rsp_err;
    logic             busy;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;

    int alu_delay = 0;
    int dly_tab [int];
    bit inject_done = 1'b0;
    int n_starts = 0;
    int start_cyc = 0;
    logic [3:0] last_op = '0;

    alu_op_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_start(alu_start), .alu_done(alu_done),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_opcode(rsp_opcode), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_fn(input logic [3:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            default: return a ^ b ^ {op, op};
        endcase
    endfunction

    function automatic logic [3:0] flg_fn(input logic [7:0] r);
        return {r[7], r == 8'd0, 2'b00};
    endfunction

    // ALU model: done arrives d WAIT cycles after the first WAIT cycle; d<0 never
    initial begin
        logic [7:0] p_res;
        logic [3:0] p_flg;
        bit pend;
        int cnt;
        int d;
        pend = 1'b0;
        cnt = 0;
        p_res = '0;
        p_flg = '0;
        alu_done = 1'b0;
        alu_result = '0;
        alu_flags = '0;
        forever begin
            @(negedge clk);
            alu_done = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    alu_done = 1'b1;
                    alu_result = p_res;
                    alu_flags = p_flg;
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (inject_done) begin
                alu_done = 1'b1;
                alu_result = 8'hA5;
                alu_flags = 4'hF;
            end
            if (alu_start === 1'b1) begin
                d = dly_tab.exists(n_starts) ? dly_tab[n_starts] : alu_delay;
                n_starts++;
                last_op = alu_opcode;
                start_cyc = cyc;
                p_res = alu_fn(alu_opcode, alu_a, alu_b);
                p_flg = flg_fn(p_res);
                pend = (d >= 0);
                cnt = d;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b);
        int t;
        t = 0;
        req_valid = 1'b1;
        req_opcode = op;
        req_a = a;
        req_b = b;
        while (!req_ready && t < 200) begin
            tick();
            t++;
        end
        vecs++;
        if (!req_ready) begin
            errs++;
            $display("FAIL push_ready got %b exp 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output bit ok);
        int t;
        t = 0;
        while (!rsp_valid && t < limit) begin
            tick();
            t++;
        end
        ok = rsp_valid;
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vecs++;
        if ({alu_start, alu_opcode, alu_a, alu_b} !== '0) begin
            errs++;
            $display("FAIL reset_alu got %b exp 0",
                     {alu_start, alu_opcode, alu_a, alu_b});
        end
        vecs++;
        if ({rsp_valid, rsp_result, rsp_flags, rsp_opcode, rsp_err, busy} !== '0) begin
            errs++;
            $display("FAIL reset_rsp got %b exp 0",
                     {rsp_valid, rsp_result, rsp_flags, rsp_opcode, rsp_err, busy});
        end
        rst_n = 1'b1;
        tick();
        vecs++;
        if (req_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_ready got %b exp 1", req_ready);
        end
    endtask

    task automatic test_single_op();
        int s0;
        bit ok;
        s0 = n_starts;
        push(4'h0, 8'h05, 8'h03);
        wait_rsp(20, ok);
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL single_rsp_valid got 0 exp 1");
        end
        vecs++;
        if (n_starts - s0 != 1 || last_op !== 4'h0) begin
            errs++;
            $display("FAIL single_start got %0d/%h exp 1/0", n_starts - s0, last_op);
        end
        vecs++;
        if (cyc - start_cyc != 2) begin
            errs++;
            $display("FAIL single_latency got %0d exp 2", cyc - start_cyc);
        end
        vecs++;
        if ({rsp_result, rsp_flags, rsp_opcode, rsp_err} !== {8'h08, 4'h0, 4'h0, 1'b0}) begin
            errs++;
            $display("FAIL single_fields got %h/%h/%h/%b exp 08/0/0/0",
                     rsp_result, rsp_flags, rsp_opcode, rsp_err);
        end
        accept();
        vecs++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL single_idle got %b%b exp 00", rsp_valid, busy);
        end
    endtask

    task automatic test_fill();
        logic [3:0] ops [5];
        logic [7:0] as [5];
        logic [7:0] bs [5];
        logic [3:0] legal [5];
        bit ok;
        legal = '{4'h0, 4'h1, 4'h8, 4'h9, 4'hC};
        alu_delay = 10;
        for (int i = 0; i < 5; i++) begin
            ops[i] = legal[i];
            as[i] = 8'($urandom);
            bs[i] = 8'($urandom);
        end
        for (int i = 0; i < 5; i++) push(ops[i], as[i], bs[i]);
        vecs++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL fill_full got ready=%b busy=%b exp 0/1", req_ready, busy);
        end
        for (int i = 0; i < 5; i++) begin
            wait_rsp(60, ok);
            vecs++;
            if (!ok || rsp_opcode !== ops[i] || rsp_err !== 1'b0 ||
                rsp_result !== alu_fn(ops[i], as[i], bs[i])) begin
                errs++;
                $display("FAIL fill_rsp%0d got %b/%h/%b/%h exp 1/%h/0/%h", i, ok,
                         rsp_opcode, rsp_err, rsp_result, ops[i],
                         alu_fn(ops[i], as[i], bs[i]));
            end
            accept();
        end
        vecs++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            errs++;
            $display("FAIL fill_drain got busy=%b ready=%b exp 0/1", busy, req_ready);
        end
        alu_delay = 0;
    endtask

    task automatic test_timeout();
        int s0;
        bit ok;
        s0 = n_starts;
        alu_delay = -1;
        push(4'h1, 8'h40, 8'h11);
        push(4'h0, 8'h22, 8'h33);
        wait_rsp(60, ok);
        vecs++;
        if (!ok || {rsp_result, rsp_flags, rsp_opcode, rsp_err} !== {8'h00, 4'h0, 4'h1, 1'b1}) begin
            errs++;
            $display("FAIL timeout_rsp got %b %h/%h/%h/%b exp 1 00/0/1/1", ok,
                     rsp_result, rsp_flags, rsp_opcode, rsp_err);
        end
        vecs++;
        if (cyc - start_cyc != TIMEOUT + 1 || n_starts - s0 != 1) begin
            errs++;
            $display("FAIL timeout_len got %0d starts %0d exp %0d starts 1",
                     cyc - start_cyc, n_starts - s0, TIMEOUT + 1);
        end
        alu_delay = 0;
        accept();
        wait_rsp(20, ok);
        vecs++;
        if (!ok || rsp_err !== 1'b0 || rsp_opcode !== 4'h0 || rsp_result !== 8'h55) begin
            errs++;
            $display("FAIL timeout_next got %b %b/%h/%h exp 1 0/0/55", ok,
                     rsp_err, rsp_opcode, rsp_result);
        end
        accept();
    endtask

    task automatic test_backpressure();
        logic [16:0] snap;
        logic [7:0] ea;
        logic [7:0] eb;
        int s0;
        bit ok;
        ea = 8'($urandom);
        eb = 8'($urandom);
        push(4'h8, ea, eb);
        push(4'h9, eb, ea);
        wait_rsp(20, ok);
        snap = {rsp_result, rsp_flags, rsp_opcode, rsp_err};
        s0 = n_starts;
        vecs++;
        if (!ok || snap !== {alu_fn(4'h8, ea, eb), flg_fn(alu_fn(4'h8, ea, eb)), 4'h8, 1'b0}) begin
            errs++;
            $display("FAIL bp_first got %b %h", ok, snap);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            vecs++;
            if (rsp_valid !== 1'b1 || n_starts != s0 ||
                {rsp_result, rsp_flags, rsp_opcode, rsp_err} !== snap) begin
                errs++;
                $display("FAIL bp_hold%0d got %b %0d %h exp 1 %0d %h", i, rsp_valid,
                         n_starts, {rsp_result, rsp_flags, rsp_opcode, rsp_err}, s0, snap);
            end
        end
        accept();
        wait_rsp(20, ok);
        vecs++;
        if (!ok || n_starts != s0 + 1 || rsp_opcode !== 4'h9 ||
            rsp_result !== alu_fn(4'h9, eb, ea)) begin
            errs++;
            $display("FAIL bp_next got %b %0d %h %h exp 1 %0d 9 %h", ok, n_starts,
                     rsp_opcode, rsp_result, s0 + 1, alu_fn(4'h9, eb, ea));
        end
        accept();
    endtask

    task automatic test_reset_midwait();
        int t;
        int s0;
        s0 = n_starts;
        t = 0;
        alu_delay = -1;
        push(4'h1, 8'h77, 8'h01);
        while (n_starts == s0 && t < 20) begin
            tick();
            t++;
        end
        vecs++;
        if (n_starts == s0) begin
            errs++;
            $display("FAIL rstw_start got 0 starts exp 1");
        end
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vecs++;
        if ({alu_start, alu_opcode, alu_a, alu_b, rsp_valid, rsp_result,
             rsp_flags, rsp_opcode, rsp_err, busy, req_ready} !== 47'd1) begin
            errs++;
            $display("FAIL rstw_outputs got %h exp 1", {alu_start, alu_opcode, alu_a,
                     alu_b, rsp_valid, rsp_result, rsp_flags, rsp_opcode, rsp_err,
                     busy, req_ready});
        end
        inject_done = 1'b1;
        tick();
        inject_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vecs++;
            if (rsp_valid !== 1'b0 || alu_start !== 1'b0 || busy !== 1'b0) begin
                errs++;
                $display("FAIL rstw_stale%0d got %b%b%b exp 000", i,
                         rsp_valid, alu_start, busy);
            end
        end
        alu_delay = 0;
    endtask

    task automatic test_opcode_check();
        int s0;
        bit ok;
        s0 = n_starts;
        push(4'hF, 8'h12, 8'h34);
        wait_rsp(20, ok);
`ifdef OPCODE_CHECK_EN
        vecs++;
        if (!ok || n_starts != s0 || {rsp_result, rsp_flags, rsp_opcode, rsp_err} !==
            {8'h00, 4'h0, 4'hF, 1'b1}) begin
            errs++;
            $display("FAIL opchk_reject got %b %0d %h exp 1 %0d 00/0/f/1", ok,
                     n_starts, {rsp_result, rsp_flags, rsp_opcode, rsp_err}, s0);
        end
`else
        vecs++;
        if (!ok || n_starts != s0 + 1 || last_op !== 4'hF || rsp_err !== 1'b0 ||
            rsp_result !== alu_fn(4'hF, 8'h12, 8'h34)) begin
            errs++;
            $display("FAIL opchk_issue got %b %0d %h %b %h exp 1 %0d f 0 %h", ok,
                     n_starts, last_op, rsp_err, rsp_result, s0 + 1,
                     alu_fn(4'hF, 8'h12, 8'h34));
        end
`endif
        accept();
    endtask

    task automatic test_random();
        localparam int N = 40;
        logic [3:0] legal [9];
        logic [3:0] ops [N];
        logic [7:0] as [N];
        logic [7:0] bs [N];
        logic [16:0] exp_r [N];
        int base;
        int d;
        legal = '{4'h0, 4'h1, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
        base = n_starts;
        for (int i = 0; i < N; i++) begin
            ops[i] = legal[$urandom_range(0, 8)];
            as[i] = 8'($urandom);
            bs[i] = 8'($urandom);
            d = (i % 5 == 0) ? TIMEOUT - 1 : (i % 5 == 1) ? TIMEOUT :
                int'($urandom_range(0, 20));
            dly_tab[base + i] = d;
            if (d < TIMEOUT) begin
                exp_r[i] = {alu_fn(ops[i], as[i], bs[i]),
                            flg_fn(alu_fn(ops[i], as[i], bs[i])), ops[i], 1'b0};
            end else begin
                exp_r[i] = {8'h00, 4'h0, ops[i], 1'b1};
            end
        end
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    push(ops[i], as[i], bs[i]);
                end
            end
            begin
                for (int i = 0; i < N; i++) begin
                    int t;
                    bit got;
                    t = 0;
                    got = 1'b0;
                    while (!got && t < 400) begin
                        rsp_ready = 1'($urandom_range(0, 1));
                        if (rsp_valid && rsp_ready) begin
                            got = 1'b1;
                            vecs++;
                            if ({rsp_result, rsp_flags, rsp_opcode, rsp_err} !== exp_r[i]) begin
                                errs++;
                                $display("FAIL rand_rsp%0d got %h exp %h", i,
                                         {rsp_result, rsp_flags, rsp_opcode, rsp_err},
                                         exp_r[i]);
                            end
                        end
                        tick();
                        t++;
                    end
                    rsp_ready = 1'b0;
                    if (!got) begin
                        vecs++;
                        errs++;
                        $display("FAIL rand_wait%0d got no response exp response", i);
                    end
                end
            end
        join
        dly_tab.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_op();
        test_fill();
        test_timeout();
        test_backpressure();
        test_reset_midwait();
        test_opcode_check();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
